// File: rtl/dm_store_buffer_if.sv
// Bundle of the core-side and memory-side buses of the posted-write store buffer.
// The buffer itself uses the slave view; the core/memory environment uses the master view.
interface dm_store_buffer_if #(
    parameter int CNT_W = 3
);
    // Core M-stage data port
    logic [31:0]      cpu_addr;
    logic [31:0]      cpu_wdata;
    logic [3:0]       cpu_byteen;
    logic [31:0]      cpu_rdata;

    // Status towards the hazard unit
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;

    // Drain port: an entry transfers on a cycle where mem_req && mem_gnt are both high at
    // the rising edge. mem_req is never withdrawn and mem_addr/mem_wdata/mem_byteen never
    // change while mem_req is high and mem_gnt is low. mem_gnt without mem_req is ignored.
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_byteen;
    logic             mem_gnt;

    // Combinational read port
    logic [31:0]      mem_raddr;
    logic [31:0]      mem_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_byteen, mem_gnt, mem_rdata,
        output cpu_rdata, full, empty, count, overflow,
               mem_req, mem_addr, mem_wdata, mem_byteen, mem_raddr
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_byteen, mem_gnt, mem_rdata,
        input  cpu_rdata, full, empty, count, overflow,
               mem_req, mem_addr, mem_wdata, mem_byteen, mem_raddr
    );
endinterface

// File: rtl/dm_store_buffer.sv
// Posted-write store buffer: stores are queued and drained in order over req/gnt,
// loads see memory data with still-buffered bytes merged in (youngest store wins).
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dm_store_buffer_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      waddr_q [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [3:0]       be_q    [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic             full_w;
    logic             empty_w;
    logic             store_w;
    logic             push_w;
    logic             pop_w;
    logic             drop_w;
    logic             unused_addr_lsb;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);
    assign store_w = |bus.cpu_byteen;
    assign push_w  = store_w && !full_w;
    // A full buffer drops the store even if the head drains this same cycle.
    assign drop_w  = store_w && full_w;
    assign pop_w   = !empty_w && bus.mem_gnt;

    assign unused_addr_lsb = ^bus.cpu_addr[1:0];

    // Pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_w) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop_w) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push_w, pop_w})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop_w) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Entry storage is written only at the tail on a push
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                waddr_q[e] <= '0;
                data_q[e]  <= '0;
                be_q[e]    <= '0;
            end
        end else if (push_w) begin
            waddr_q[tail_q] <= bus.cpu_addr[31:2];
            data_q[tail_q]  <= bus.cpu_wdata;
            be_q[tail_q]    <= bus.cpu_byteen;
        end
    end

    // Drain port straight from head registers, forced to zero while empty
    always_comb begin
        bus.mem_req    = !empty_w;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_byteen = '0;
        if (!empty_w) begin
            bus.mem_addr   = {waddr_q[head_q], 2'b00};
            bus.mem_wdata  = data_q[head_q];
            bus.mem_byteen = be_q[head_q];
        end
    end

    // Walk entries oldest to youngest so a younger match overwrites an older one per lane.
    logic [PTR_W-1:0] idx;
    logic [31:0]      rdata;

    always_comb begin
        idx   = '0;
        rdata = bus.mem_rdata;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (waddr_q[idx] == bus.cpu_addr[31:2])) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_q[idx][i]) begin
                        rdata[8*i +: 8] = data_q[idx][8*i +: 8];
                    end
                end
            end
        end
    end

    assign bus.cpu_rdata = rdata;
    assign bus.mem_raddr = {bus.cpu_addr[31:2], 2'b00};

    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed bench for dm_store_buffer: reset, queueing, load merge, ordering,
// full/overflow behaviour, pointer wrap under continuous drain and asynchronous reset.
module tb_dm_store_buffer;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  logic [31:0] exp_q[$];

  dm_store_buffer_if #(.CNT_W(3)) bus ();

  dm_store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change and outputs are sampled 2 time units after a rising edge
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.cpu_addr   = a;
    bus.cpu_wdata  = d;
    bus.cpu_byteen = be;
    cycle();
    bus.cpu_byteen = 4'b0000;
  endtask

  task automatic test_reset();
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    // gnt without req must be ignored
    bus.mem_gnt = 1'b1;
    cycle();
    bus.mem_gnt = 1'b0;
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL idle_gnt_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_single();
    store(32'h100, 32'h11223344, 4'b1111);
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.count); end
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL single_addr: got %h want 00000100", bus.mem_addr); end
    checks++; if (bus.mem_byteen !== 4'b1111) begin errors++; $display("FAIL single_be: got %b want 1111", bus.mem_byteen); end
    checks++; if (bus.mem_wdata !== 32'h11223344) begin errors++; $display("FAIL single_wdata: got %h want 11223344", bus.mem_wdata); end
    // Without gnt the head must hold
    cycle();
    checks++; if (bus.mem_addr !== 32'h100 || bus.count !== 3'd1) begin errors++; $display("FAIL single_hold: got addr %h count %0d want 00000100 1", bus.mem_addr, bus.count); end
    bus.mem_gnt = 1'b1;
    cycle();
    bus.mem_gnt = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_drained_empty: got %b want 1", bus.empty); end
    checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL single_drained_wdata: got %h want 0", bus.mem_wdata); end
  endtask

  task automatic test_merge();
    store(32'h201, 32'h0000AB00, 4'b0010);
    bus.cpu_addr  = 32'h200;
    bus.mem_rdata = 32'hFFFFFFFF;
    #1;
    checks++; if (bus.cpu_rdata !== 32'hFFFFABFF) begin errors++; $display("FAIL merge_ff: got %h want FFFFABFF", bus.cpu_rdata); end
    bus.cpu_addr  = 32'h203;
    bus.mem_rdata = 32'h12345678;
    #1;
    checks++; if (bus.cpu_rdata !== 32'h1234AB78) begin errors++; $display("FAIL merge_pattern: got %h want 1234AB78", bus.cpu_rdata); end
    checks++; if (bus.mem_raddr !== 32'h200) begin errors++; $display("FAIL merge_raddr: got %h want 00000200", bus.mem_raddr); end
    bus.cpu_addr = 32'h204;
    #1;
    checks++; if (bus.cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL merge_nomatch: got %h want 12345678", bus.cpu_rdata); end
    // Entry being granted still participates
    bus.cpu_addr = 32'h200;
    bus.mem_gnt  = 1'b1;
    #1;
    checks++; if (bus.cpu_rdata !== 32'h1234AB78) begin errors++; $display("FAIL merge_granted: got %h want 1234AB78", bus.cpu_rdata); end
    cycle();
    bus.mem_gnt = 1'b0;
    #1;
    checks++; if (bus.cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL merge_after_drain: got %h want 12345678", bus.cpu_rdata); end
  endtask

  task automatic test_youngest();
    store(32'h300, 32'h00000001, 4'b1111);
    store(32'h300, 32'h00000002, 4'b1111);
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h00000002);
    bus.cpu_addr  = 32'h300;
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.cpu_rdata !== 32'h00000002) begin errors++; $display("FAIL youngest_load: got %h want 00000002", bus.cpu_rdata); end
    for (int n = 0; n < 10 && !bus.empty; n++) begin
      bus.mem_gnt = 1'b1;
      if (bus.mem_req) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL youngest_extra_pop: got %h want none", bus.mem_wdata); end
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (bus.mem_wdata !== e || bus.mem_addr !== 32'h300) begin errors++; $display("FAIL youngest_order: got %h @%h want %h @00000300", bus.mem_wdata, bus.mem_addr, e); end
        end
      end
      cycle();
    end
    bus.mem_gnt = 1'b0;
    checks++; if (bus.empty !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL youngest_drain_done: got empty %b left %0d want 1 0", bus.empty, exp_q.size()); end
  endtask

  task automatic test_full_overflow();
    for (int k = 0; k < 4; k++) begin
      store(32'h400 + 32'(4*k), 32'hA0 + 32'(k), 4'b1111);
    end
    checks++; if (bus.full !== 1'b1 || bus.count !== 3'd4) begin errors++; $display("FAIL full_after4: got full %b count %0d want 1 4", bus.full, bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL no_overflow_yet: got %b want 0", bus.overflow); end
    store(32'h410, 32'hA4, 4'b1111);
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4) begin errors++; $display("FAIL overflow_5th: got ovf %b count %0d want 1 4", bus.overflow, bus.count); end
    // Pop in the same cycle does not rescue a store to a full buffer
    bus.mem_gnt = 1'b1;
    checks++; if (bus.mem_wdata !== 32'hA0) begin errors++; $display("FAIL full_head: got %h want 000000a0", bus.mem_wdata); end
    store(32'h414, 32'hA5, 4'b1111);
    bus.mem_gnt = 1'b0;
    checks++; if (bus.count !== 3'd3 || bus.full !== 1'b0) begin errors++; $display("FAIL drop_with_pop: got count %0d full %b want 3 0", bus.count, bus.full); end
    exp_q.push_back(32'hA1);
    exp_q.push_back(32'hA2);
    exp_q.push_back(32'hA3);
    for (int n = 0; n < 10 && !bus.empty; n++) begin
      bus.mem_gnt = 1'b1;
      if (bus.mem_req) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL full_extra_pop: got %h want none", bus.mem_wdata); end
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (bus.mem_wdata !== e) begin errors++; $display("FAIL full_drain_order: got %h want %h", bus.mem_wdata, e); end
        end
      end
      cycle();
    end
    bus.mem_gnt = 1'b0;
    checks++; if (bus.empty !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL full_drain_done: got empty %b left %0d want 1 0", bus.empty, exp_q.size()); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b want 1", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    store(32'h500, 32'hC0, 4'b1111);
    store(32'h504, 32'hC1, 4'b1111);
    exp_q.push_back(32'hC0);
    exp_q.push_back(32'hC1);
    checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count_start: got %0d want 2", bus.count); end
    for (int k = 2; k < 8; k++) begin
      bus.mem_gnt = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra_pop: got %h want none", bus.mem_wdata); end
      else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.mem_wdata !== e) begin errors++; $display("FAIL b2b_order: got %h want %h", bus.mem_wdata, e); end
      end
      exp_q.push_back(32'hC0 + 32'(k));
      store(32'h500 + 32'(4*k), 32'hC0 + 32'(k), 4'b1111);
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count_steady: got %0d want 2", bus.count); end
    end
    for (int n = 0; n < 10 && !bus.empty; n++) begin
      bus.mem_gnt = 1'b1;
      if (bus.mem_req) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_tail_extra: got %h want none", bus.mem_wdata); end
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (bus.mem_wdata !== e) begin errors++; $display("FAIL b2b_tail_order: got %h want %h", bus.mem_wdata, e); end
        end
      end
      cycle();
    end
    bus.mem_gnt = 1'b0;
    checks++; if (bus.empty !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_done: got empty %b left %0d want 1 0", bus.empty, exp_q.size()); end
  endtask

  task automatic test_reset_mid_drain();
    store(32'h600, 32'hB0, 4'b1111);
    store(32'h604, 32'hB1, 4'b1111);
    store(32'h608, 32'hB2, 4'b0011);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL mid_count: got %0d want 3", bus.count); end
    bus.mem_gnt = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL async_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin errors++; $display("FAIL async_empty: got empty %b count %0d want 1 0", bus.empty, bus.count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL async_overflow: got %b want 0", bus.overflow); end
    checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_byteen !== 4'h0) begin errors++; $display("FAIL async_bus_zero: got %h %h %b want 0 0 0", bus.mem_addr, bus.mem_wdata, bus.mem_byteen); end
    bus.mem_gnt = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    bus.cpu_addr  = 32'h600;
    bus.mem_rdata = 32'h5A5A5A5A;
    #1;
    checks++; if (bus.cpu_rdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL post_reset_merge: got %h want 5A5A5A5A", bus.cpu_rdata); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %b want 1", bus.empty); end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    reset_n        = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_byteen = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rdata  = '0;
    #7;
    reset_n = 1'b1;
    #1;
    test_reset();
    test_single();
    test_merge();
    test_youngest();
    test_full_overflow();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
